// File: rtl/layer_channel_serializer.sv
// Pixel-word FIFO feeding a channel-serial valid/ready stream; one channel value per output beat.
// Optional per-frame pixel counter driving Frame_Last is built only when LAYER_SER_FRAME_EOF_EN is defined.
module layer_channel_serializer #(
    parameter int DATA_WIDHT  = 32,
    parameter int CHANNEL_OUT = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int IMG_WIDHT   = 220,
    parameter int IMG_HEIGHT  = 220
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDHT*CHANNEL_OUT-1:0] Data_In,
    input  logic                              Valid_In,
    output logic [DATA_WIDHT-1:0]             Data_Out,
    output logic                              Valid_Out,
    input  logic                              Ready_Out,
    output logic [$clog2(CHANNEL_OUT)-1:0]    Channel_Idx,
    output logic                              Last_Channel,
    output logic                              Frame_Last,
    output logic                              Overflow
);
    localparam int CH_W = $clog2(CHANNEL_OUT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef logic [CHANNEL_OUT-1:0][DATA_WIDHT-1:0] pix_t;
    typedef enum logic {IDLE, SEND} state_t;

    pix_t                  mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    state_t                state_q, state_d;
    pix_t                  hold_q, hold_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [DATA_WIDHT-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic                  ovf_q, ovf_d;
    logic                  fifo_empty, fifo_full, beat, last_ch, pop, push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign beat       = vld_q & Ready_Out;
    assign last_ch    = (ch_q == CH_W'(CHANNEL_OUT - 1));

    // Output FSM: a pop loads the holding register and presents channel 0 in the same edge.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ch_d    = ch_q;
        data_d  = data_q;
        vld_d   = vld_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    ch_d    = '0;
                    data_d  = mem_q[rd_ptr_q][0];
                    vld_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    if (!last_ch) begin
                        ch_d   = ch_q + CH_W'(1);
                        data_d = hold_q[ch_q + CH_W'(1)];
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        hold_d = mem_q[rd_ptr_q];
                        ch_d   = '0;
                        data_d = mem_q[rd_ptr_q][0];
                    end else begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push  = Valid_In & (~fifo_full | pop);
    assign ovf_d = ovf_q | (Valid_In & fifo_full & ~pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Data_In;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            ch_q     <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign Data_Out     = data_q;
    assign Valid_Out    = vld_q;
    assign Channel_Idx  = ch_q;
    assign Overflow     = ovf_q;
    assign Last_Channel = vld_q & last_ch;

`ifdef LAYER_SER_FRAME_EOF_EN
    localparam int PIX_TOTAL = IMG_WIDHT * IMG_HEIGHT;
    localparam int PIX_W     = $clog2(PIX_TOTAL);

    logic [PIX_W-1:0] pix_q, pix_d;
    logic             pix_end;

    assign pix_end = (pix_q == PIX_W'(PIX_TOTAL - 1));

    always_comb begin
        pix_d = pix_q;
        if (Last_Channel & Ready_Out) begin
            pix_d = pix_end ? '0 : pix_q + PIX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign Frame_Last = Last_Channel & pix_end;
`else
    assign Frame_Last = 1'b0;
`endif

endmodule

// File: tb/tb_layer_channel_serializer.sv
// Bench for layer_channel_serializer: queue-based reference model checked every cycle plus directed literal checks.
module tb_layer_channel_serializer;
    localparam int DW    = 32;
    localparam int CH    = 8;
    localparam int DEPTH = 4;
    localparam int IMG_W = 2;
    localparam int IMG_H = 2;
    localparam int TOT   = IMG_W * IMG_H;

    logic              clk, rst;
    logic [DW*CH-1:0]  Data_In;
    logic              Valid_In, Ready_Out;
    logic [DW-1:0]     Data_Out;
    logic              Valid_Out, Last_Channel, Frame_Last, Overflow;
    logic [2:0]        Channel_Idx;

    int checks = 0;
    int errors = 0;

    layer_channel_serializer #(
        .DATA_WIDHT(DW), .CHANNEL_OUT(CH), .FIFO_DEPTH(DEPTH),
        .IMG_WIDHT(IMG_W), .IMG_HEIGHT(IMG_H)
    ) dut (
        .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
        .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Ready_Out(Ready_Out),
        .Channel_Idx(Channel_Idx), .Last_Channel(Last_Channel),
        .Frame_Last(Frame_Last), .Overflow(Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending words, the pixel in flight, and its next channel.
    logic [DW*CH-1:0] pend[$];
    logic [DW*CH-1:0] m_pix;
    bit               m_act, m_ovf, m_beat, m_lastb, m_pop;
    int               m_ch, m_pixcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_pix = '0; m_act = 0; m_ovf = 0; m_ch = 0; m_pixcnt = 0;
        end else begin
            m_beat  = m_act && Ready_Out;
            m_lastb = m_beat && (m_ch == CH - 1);
            m_pop   = (pend.size() > 0) && (!m_act || m_lastb);
            if (m_lastb) m_pixcnt = (m_pixcnt + 1) % TOT;
            if (m_pop) begin
                m_pix = pend.pop_front();
                m_ch  = 0;
                m_act = 1;
            end else if (m_lastb) begin
                m_act = 0;
            end else if (m_beat) begin
                m_ch++;
            end
            if (Valid_In) begin
                if (pend.size() < DEPTH) pend.push_back(Data_In);
                else m_ovf = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_fl;
`ifdef LAYER_SER_FRAME_EOF_EN
        exp_fl = m_act && (m_ch == CH - 1) && (m_pixcnt == TOT - 1);
`else
        exp_fl = 1'b0;
`endif
        chk("m_valid", Valid_Out, m_act);
        chk("m_overflow", Overflow, m_ovf);
        chk("m_last", Last_Channel, m_act && (m_ch == CH - 1));
        chk("m_frame_last", Frame_Last, exp_fl);
        if (m_act) begin
            chk("m_data", Data_Out, m_pix[m_ch*DW +: DW]);
            chk("m_idx", Channel_Idx, m_ch[2:0]);
        end
    end

    function automatic logic [DW*CH-1:0] mk_pix(input logic [31:0] base);
        logic [DW*CH-1:0] p;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = base + k;
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int idx, input string name);
        int n = 0;
        while (!(Valid_Out && Channel_Idx == idx) && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n, fl_n, fl_sum, beats;
        rst = 1'b1; Valid_In = 1'b0; Ready_Out = 1'b0; Data_In = '0;
        repeat (3) cyc();
        chk("rst_valid", Valid_Out, 0);
        chk("rst_data", Data_Out, 0);
        chk("rst_idx", Channel_Idx, 0);
        chk("rst_ovf", Overflow, 0);
        #1 rst = 1'b0;
        cyc();

        // One pixel, two-cycle latency, channels in order.
        #1 Ready_Out = 1'b1; Valid_In = 1'b1; Data_In = mk_pix(32'h100);
        cyc();
        chk("t1_lat_low", Valid_Out, 0);
        #1 Valid_In = 1'b0;
        cyc();
        for (int k = 0; k < CH; k++) begin
            chk("t1_valid", Valid_Out, 1);
            chk("t1_data", Data_Out, 32'h100 + k);
            chk("t1_idx", Channel_Idx, k);
            chk("t1_last", Last_Channel, (k == CH - 1));
            cyc();
        end
        chk("t1_end", Valid_Out, 0);

        // Stall at channel 3.
        #1 Valid_In = 1'b1; Data_In = mk_pix(32'h100);
        cyc();
        #1 Valid_In = 1'b0;
        wait_idx(3, "t2");
        #1 Ready_Out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_hold_data", Data_Out, 32'h103);
            chk("t2_hold_idx", Channel_Idx, 3);
        end
        #1 Ready_Out = 1'b1;
        cyc();
        chk("t2_resume", Data_Out, 32'h104);
        repeat (8) cyc();

        // Two back-to-back pixels stream without a bubble.
        #1 Valid_In = 1'b1; Data_In = mk_pix(32'h500);
        cyc();
        #1 Data_In = mk_pix(32'h600);
        cyc();
        #1 Valid_In = 1'b0;
        n = 0;
        while (!Valid_Out && n < 10) begin cyc(); n++; end
        n = 0;
        while (Valid_Out && n < 40) begin cyc(); n++; end
        chk("t3_contig", n, 16);
        repeat (3) cyc();

        // Overflow: six words into a stalled block.
        #1 Ready_Out = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 Valid_In = 1'b1; Data_In = mk_pix(32'h200 + 32'h10 * i);
            cyc();
        end
        #1 Valid_In = 1'b0;
        cyc();
        chk("t4_ovf", Overflow, 1);
        #1 Ready_Out = 1'b1;
        n = 0;
        while (Valid_Out && n < 100) begin cyc(); n++; end
        chk("t4_beats", n, 40);
        repeat (4) cyc();

        // Reset mid-pixel.
        #1 Valid_In = 1'b1; Data_In = mk_pix(32'h300);
        cyc();
        #1 Valid_In = 1'b0;
        wait_idx(4, "t5");
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", Valid_Out, 0);
        chk("t5_data", Data_Out, 0);
        chk("t5_idx", Channel_Idx, 0);
        chk("t5_ovf", Overflow, 0);
        chk("t5_last", Last_Channel, 0);
        cyc();
        #1 rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n += Valid_Out;
        end
        chk("t5_silent", n, 0);

        // Frame marker over eight pixels of a 2x2 frame.
        fl_n = 0; fl_sum = 0; beats = 0;
        for (int p = 0; p < 8; p++) begin
            #1 Valid_In = 1'b1; Data_In = mk_pix(32'h1000 * (p + 1));
            for (int c = 0; c < 10; c++) begin
                cyc();
                if (Valid_Out && Ready_Out) begin
                    beats++;
                    if (Frame_Last) begin fl_n++; fl_sum += beats; end
                end
                #1 Valid_In = 1'b0;
            end
        end
        chk("t6_beats", beats, 64);
`ifdef LAYER_SER_FRAME_EOF_EN
        chk("t6_fl_count", fl_n, 2);
        chk("t6_fl_pos", fl_sum, 32 + 64);
`else
        chk("t6_fl_count", fl_n, 0);
        chk("t6_fl_pos", fl_sum, 0);
`endif

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            cyc();
            #1;
            Valid_In  = ((i / 500) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
            for (int k = 0; k < CH; k++) Data_In[k*DW +: DW] = $urandom;
            Ready_Out = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) == 0);
        end
        #1 rst = 1'b0; Valid_In = 1'b0;
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
